// File: rtl/wmaj_pkg.sv
// wmaj_pkg: shared widths and weight function for the weighted-majority channel scheduler
package wmaj_pkg;
  function automatic int wmaj_sw(input int win);
    return $clog2(win * (win + 1) / 2 + 1) + 1;
  endfunction
  function automatic int wmaj_weight(input int win, input int k);
    return win - k;
  endfunction
  function automatic int wmaj_cw(input int nch);
    return $clog2(nch);
  endfunction
endpackage

// File: rtl/wmaj_score.sv
// wmaj_score: combinational signed weighted sum of a bit window (bit 0 newest), only the first fill positions count
module wmaj_score import wmaj_pkg::*; #(
  parameter int WIN = 8,
  parameter int SW = wmaj_sw(WIN),
  parameter int FW = $clog2(WIN + 1)
) (
  input  logic [WIN-1:0]       win,
  input  logic [FW-1:0]        fill,
  output logic signed [SW-1:0] score
);
  int acc;
  always_comb begin
    acc = 0;
    for (int k = 0; k < WIN; k++)
      acc = acc + ((k < int'(fill)) ? (win[k] ? wmaj_weight(WIN, k) : -wmaj_weight(WIN, k)) : 0);
    score = SW'(acc);
  end
endmodule

// File: rtl/wmaj_channel_scheduler.sv
// wmaj_channel_scheduler: round-robin shares one weighted-majority trend scorer across NCH bit channels (define WMAJ_HYST_EN for hysteresis)
module wmaj_channel_scheduler import wmaj_pkg::*; #(
  parameter int NCH = 4,
  parameter int WIN = 8,
  parameter int HYST = 4,
  localparam int CW = wmaj_cw(NCH),
  localparam int SW = wmaj_sw(WIN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       ch_valid,
  input  logic [NCH-1:0]       ch_bit,
  output logic [NCH-1:0]       ch_ready,
  input  logic [NCH-1:0]       ch_clr,
  output logic [NCH-1:0]       trend,
  output logic                 res_valid,
  output logic [CW-1:0]        res_ch,
  output logic signed [SW-1:0] res_score
);
  localparam int FW = $clog2(WIN + 1);
  logic [NCH-1:0] pend, pbit, gnt;
  logic [NCH-1:0][WIN-1:0] win;
  logic [NCH-1:0][FW-1:0] fill;
  logic [CW-1:0] rr_ptr, g, s1_ch;
  logic gv, s1_vld, s1_bit, kill, t_set, t_clr;
  logic [WIN-1:0] win_n;
  logic [FW-1:0] fill_n;
  logic signed [SW-1:0] score;
  always_comb begin
    gv = 1'b0;
    g = '0;
    for (int j = NCH - 1; j >= 0; j--)
      if (pend[rr_ptr + CW'(j)] & ~ch_clr[rr_ptr + CW'(j)]) begin
        gv = 1'b1;
        g = rr_ptr + CW'(j);
      end
  end
  assign gnt = gv ? (NCH'(1) << g) : '0;
  assign ch_ready = ~ch_clr & (~pend | gnt);
  assign win_n = {win[s1_ch][WIN-2:0], s1_bit};
  assign fill_n = fill[s1_ch] + FW'(fill[s1_ch] != FW'(WIN));
  assign kill = ch_clr[s1_ch];
  wmaj_score #(.WIN(WIN), .SW(SW), .FW(FW)) u_score (.win(win_n), .fill(fill_n), .score(score));
`ifdef WMAJ_HYST_EN
  assign t_set = score >= SW'(HYST);
  assign t_clr = score <= -SW'(HYST);
`else
  logic unused_hyst;
  assign unused_hyst = ^HYST;
  assign t_set = ~score[SW-1] & (|score);
  assign t_clr = score[SW-1];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      pbit <= '0;
      win <= '0;
      fill <= '0;
      trend <= '0;
      rr_ptr <= '0;
      s1_vld <= 1'b0;
      s1_ch <= '0;
      s1_bit <= 1'b0;
      res_valid <= 1'b0;
      res_ch <= '0;
      res_score <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_valid[i] & ch_ready[i]) begin
          pend[i] <= 1'b1;
          pbit[i] <= ch_bit[i];
        end else if (gnt[i] | ch_clr[i]) pend[i] <= 1'b0;
        if (ch_clr[i]) begin
          win[i] <= '0;
          fill[i] <= '0;
          trend[i] <= 1'b0;
        end else if (s1_vld && s1_ch == CW'(i)) begin
          win[i] <= win_n;
          fill[i] <= fill_n;
          trend[i] <= t_set | (trend[i] & ~t_clr);
        end
      end
      s1_vld <= gv;
      s1_ch <= g;
      s1_bit <= pbit[g];
      if (gv) rr_ptr <= g + CW'(1);
      res_valid <= s1_vld & ~kill;
      if (s1_vld & ~kill) begin
        res_ch <= s1_ch;
        res_score <= score;
      end
    end
  end
endmodule
